score_seg_display: RTL and testbench

//  Downstream of the score counter: takes its 4-bit binary score and drives the

---
 rtl/score_seg_display.sv | 153 +++++++++++++++
 tb/tb_score_seg_display.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/score_seg_display.sv
// Score-to-display driver: resynchronises the 4-bit score, splits it into decimal
// digits, multiplexes a 4-digit active-low seven-segment display and flashes on change.
`timescale 1ns/1ps
module score_seg_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_BLINKS = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] SCORE_IN,
    output logic [1:0] STROBE_COUNTER,
    output logic [3:0] SEG_ANODE,
    output logic [7:0] SEG_CATHODE
);
    localparam int PRESC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FLASH_W = $clog2(2 * FLASH_BLINKS + 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(2 * FLASH_BLINKS);

    logic [3:0]         r_s1;
    logic [3:0]         r_s2;
    logic [3:0]         r_s3;
    logic [3:0]         r_score_q;
    logic [PRESC_W-1:0] r_presc;
    logic [1:0]         r_strobe;
    logic [FLASH_W-1:0] r_flash_cnt;
    logic [3:0]         r_anode;
    logic [7:0]         r_cathode;

    logic       w_tick;
    logic       w_frame_end;
    logic       w_stable;
    logic       w_load;
    logic       w_tens_on;
    logic [3:0] w_units;
    logic       w_digit_on;
    logic [7:0] w_cathode_next;
    logic [3:0] w_anode_next;

    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // Three-flop resync; a value is accepted only once two consecutive samples agree,
    // so a multi-bit word caught mid-transition never becomes the displayed score.
    assign w_stable = (r_s2 == r_s3);
    assign w_load   = w_stable && (r_s3 != r_score_q);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_s1      <= 4'd0;
            r_s2      <= 4'd0;
            r_s3      <= 4'd0;
            r_score_q <= 4'd0;
        end else begin
            r_s1 <= SCORE_IN;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_stable) begin
                r_score_q <= r_s3;
            end
        end
    end

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_frame_end = w_tick && (r_strobe == 2'd3);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_presc  <= '0;
            r_strobe <= 2'd0;
        end else if (w_tick) begin
            r_presc  <= '0;
            r_strobe <= r_strobe + 2'd1;
        end else begin
            r_presc  <= r_presc + PRESC_W'(1);
        end
    end

    // Odd counts are blank frames; a new score restarts the whole blink sequence.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_flash_cnt <= '0;
        end else if (w_load) begin
            r_flash_cnt <= FLASH_LOAD;
        end else if (w_frame_end && (r_flash_cnt != '0)) begin
            r_flash_cnt <= r_flash_cnt - FLASH_W'(1);
        end
    end

    assign w_tens_on = (r_score_q >= 4'd10);
    assign w_units   = w_tens_on ? (r_score_q - 4'd10) : r_score_q;

    always_comb begin
        w_digit_on     = 1'b0;
        w_cathode_next = 8'hFF;
        case (r_strobe)
            2'd0: begin
                w_digit_on     = 1'b1;
                w_cathode_next = seg_code(w_units);
            end
            2'd1: begin
                if (w_tens_on) begin
                    w_digit_on     = 1'b1;
                    w_cathode_next = seg_code(4'd1);
                end
            end
            default: begin
                w_digit_on     = 1'b0;
                w_cathode_next = 8'hFF;
            end
        endcase
        if (r_flash_cnt[0]) begin
            w_digit_on     = 1'b0;
            w_cathode_next = 8'hFF;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign w_anode_next[gi] = ~(w_digit_on && (r_strobe == 2'(gi)));
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_anode   <= 4'b1111;
            r_cathode <= 8'hFF;
        end else begin
            r_anode   <= w_anode_next;
            r_cathode <= w_cathode_next;
        end
    end

    assign STROBE_COUNTER = r_strobe;
    assign SEG_ANODE      = r_anode;
    assign SEG_CATHODE    = r_cathode;

endmodule

// File: tb/tb_score_seg_display.sv
// Randomised bench for score_seg_display: outputs are compared every cycle against a
// history-based model of the score sync, refresh timing, decimal display and flashing.
`timescale 1ns/1ps
module tb_score_seg_display;
    localparam int DIV = 4;
    localparam int FB  = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] SCORE_IN = 4'd0;
    logic [1:0] STROBE_COUNTER;
    logic [3:0] SEG_ANODE;
    logic [7:0] SEG_CATHODE;

    score_seg_display #(.REFRESH_DIV(DIV), .FLASH_BLINKS(FB)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SCORE_IN       (SCORE_IN),
        .STROBE_COUNTER (STROBE_COUNTER),
        .SEG_ANODE      (SEG_ANODE),
        .SEG_CATHODE    (SEG_CATHODE)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Model state: edges since reset release, accepted score, flash count, and the
    // input samples taken at recent edges (index 0 = most recent).
    int m_k;
    int m_q;
    int m_fc;
    int hist[$];

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, exp, m_k);
        end
    endtask

    task automatic model_reset();
        m_k  = 0;
        m_q  = 0;
        m_fc = 0;
        hist = '{0, 0, 0};
    endtask

    task automatic exp_disp(input int slot, input int q, input int fc,
                            output int an, output int ca, output bit ca_chk);
        an     = 'hF;
        ca     = 'hFF;
        ca_chk = 1'b1;
        if (fc % 2 == 1) begin
            ca_chk = 1'b0;
        end else if (slot == 0) begin
            an = 'hE;
            ca = seg_lut[q % 10];
        end else if (slot == 1) begin
            if (q >= 10) begin
                an = 'hD;
                ca = seg_lut[q / 10];
            end else begin
                ca_chk = 1'b0;
            end
        end
    endtask

    task automatic drive_cycle(input logic [3:0] v);
        int  an;
        int  ca;
        bit  ca_chk;
        bit  frame_end;
        SCORE_IN = v;
        @(posedge CLK);
        #1;
        exp_disp((m_k / DIV) % 4, m_q, m_fc, an, ca, ca_chk);
        frame_end = (m_k % (4 * DIV)) == (4 * DIV - 1);
        if (hist[1] == hist[2] && hist[2] != m_q) begin
            m_q  = hist[2];
            m_fc = 2 * FB;
        end else if (frame_end && m_fc > 0) begin
            m_fc--;
        end
        hist.push_front(int'(v));
        void'(hist.pop_back());
        m_k++;
        check_val("strobe", int'(STROBE_COUNTER), (m_k / DIV) % 4);
        check_val("anode", int'(SEG_ANODE), an);
        if (ca_chk) check_val("cathode", int'(SEG_CATHODE), ca);
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        $display("hold score=%0d cycles=%0d", v, n);
        repeat (n) drive_cycle(v);
    endtask

    task automatic apply_reset();
        #3;
        RESET = 1'b1;
        #1;
        check_val("rst_anode", int'(SEG_ANODE), 'hF);
        check_val("rst_cathode", int'(SEG_CATHODE), 'hFF);
        check_val("rst_strobe", int'(STROBE_COUNTER), 0);
        $display("reset asserted mid-cycle");
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_val("por_anode", int'(SEG_ANODE), 'hF);
        check_val("por_cathode", int'(SEG_CATHODE), 'hFF);
        check_val("por_strobe", int'(STROBE_COUNTER), 0);
        RESET = 1'b0;

        hold(4'd0, 40);
        apply_reset();
        hold(4'd0, 20);

        hold(4'd7, 80);
        hold(4'd12, 80);
        hold(4'd15, 80);
        hold(4'd3, 80);
        hold(4'd4, 80);
        $display("glitch score=9 for one cycle");
        drive_cycle(4'd9);
        hold(4'd4, 80);

        // Change again while the flash sequence is partway through.
        hold(4'd5, 1);
        for (int i = 0; i < 200 && m_fc != 2; i++) drive_cycle(4'd5);
        check_val("flash_mid_reach", m_fc, 2);
        hold(4'd6, 100);

        // Reset during a blank flash frame, then steady display.
        hold(4'd9, 1);
        for (int i = 0; i < 200 && (m_fc % 2) != 1; i++) drive_cycle(4'd9);
        check_val("flash_blank_reach", m_fc % 2, 1);
        SCORE_IN = 4'd0;
        apply_reset();
        hold(4'd0, 80);

        for (int t = 0; t < 120; t++) begin
            if ($urandom_range(0, 29) == 0) begin
                apply_reset();
            end
            hold(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 40)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
